qr_text_ctrl: RTL and testbench
===============================

QR_TEXT_CTRL -- requirements
Module: qr_text_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  input  1  one-cycle request to decode the presented codeword block.
REQ-004 SHALL provide: codeword  input  352  44 corrected data bytes; byte k at bits [8k+7:8k]; byte 0 first in the bit stream; MSB-first within each byte.
REQ-005 SHALL provide: abort  input  1  synchronous cancel of the current decode.
REQ-006 SHALL provide: out_ready  input  1  downstream accepts out_data this cycle.
REQ-007 SHALL provide: out_valid  output  1  out_data holds a decoded JIS8 character.
REQ-008 SHALL provide: out_data  output  8  decoded JIS8 character.
REQ-009 SHALL provide: out_last  output  1  current character is the final one of the message.
REQ-010 SHALL provide: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL provide: done  output  1  one-cycle pulse on successful completion.
REQ-012 SHALL provide: err  output  1  one-cycle pulse on header rejection.
REQ-013 SHALL provide: err_code  output  2  sticky cause: 00 none, 01 bad mode, 10 length too long; cleared on the next accepted start.

Function
REQ-014 SHALL implement the FSM states IDLE, HEADER, STREAM, FINISH, ERROR.
REQ-015 IDLE: when start=1, SHALL latch codeword into an internal 352-bit register, clear err_code, and go to HEADER; start SHALL be ignored in every other state.
REQ-016 HEADER (one cycle): SHALL compute mode = byte0[7:4] and len = {byte0[3:0], byte1[7:4]} from the latched copy.
REQ-017 HEADER transitions: mode != 4'b0100 -> ERROR with err_code=01; else len > 42 -> ERROR with err_code=10; else len = 0 -> FINISH; else -> STREAM with char index i = 0.
REQ-018 Character i SHALL equal {byte(i+1)[3:0], byte(i+2)[7:4]}; i is a 6-bit counter.
REQ-019 STREAM: out_valid SHALL be registered high and out_data SHALL be character i; first out_valid appears 2 cycles after the start cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-021 On a handshake (out_valid & out_ready) with i < len-1: i increments, and the next character is presented in the following cycle with no bubble.
REQ-022 out_last SHALL be 1 exactly while i = len-1.
REQ-023 A handshake with out_last=1 SHALL drop out_valid the next cycle and enter FINISH.
REQ-024 FINISH SHALL assert done for one cycle, then return to IDLE.
REQ-025 ERROR SHALL assert err for one cycle, then return to IDLE; no out_valid SHALL be produced for a rejected header.
REQ-026 abort=1 in any non-IDLE state SHALL, on the next edge, force IDLE, out_valid=0 and i=0, and SHALL NOT produce a done or err pulse; abort takes priority over any concurrent handshake.
REQ-027 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-028 The latched codeword SHALL NOT change while busy=1, even if the codeword input changes.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE and set out_valid, out_last, busy, done, err = 0, out_data = 8'h00, err_code = 00, i = 0 and the latched codeword = 0.
REQ-030 Reset asserted mid-STREAM SHALL discard the message; after release, the block SHALL accept a new start normally.

Verification
REQ-031 byte0=8'h40, byte1=8'h34, bytes2..4=8'h14,8'h24,8'h30, out_ready=1 -> out_data 41,42,43 on consecutive cycles starting at cycle+2, out_last on 43, done one cycle later.
REQ-032 Same stimulus with out_ready toggling 1,0,0,1,... -> each character held stable through the stall; no character lost or duplicated.
REQ-033 byte0=8'h20 -> err pulse at cycle+2, err_code=01, no out_valid; byte0=8'h42, byte1=8'hB0 (len 43) -> err_code=10.
REQ-034 len = 0 (byte0=8'h40, byte1=8'h00) -> done at cycle+2 with no out_valid; len = 42 -> 42 characters, the last taken from byte42[3:0] and byte43[7:4].
REQ-035 abort after the 2nd handshake -> IDLE next edge, no done; a start in the same cycle as abort in IDLE is ignored; a new start afterwards decodes correctly.
REQ-036 rst pulsed mid-STREAM -> all outputs 0 asynchronously; a subsequent start decodes from the new codeword.

Source files
------------

// File: rtl/qr_text_ctrl.sv
// QR byte-mode text extractor: checks the header, then streams JIS8 characters under valid/ready.
// First character appears two cycles after start; the character is held while out_ready is low.
module qr_text_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [351:0] codeword,
  input  logic         abort,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   err_code
);

  typedef enum logic [2:0] {IDLE, HEADER, STREAM, FINISH, ERROR} state_t;

  state_t         state, state_nxt;
  logic [351:0]   cw_q;
  logic [5:0]     idx;
  logic [5:0]     idx_nxt;
  logic [3:0]     mode;
  logic [7:0]     len;
  logic           hs;
  logic           abort_hit;

  assign mode      = cw_q[7:4];
  assign len       = {cw_q[3:0], cw_q[15:12]};
  assign hs        = out_valid & out_ready;
  assign abort_hit = abort && (state != IDLE);
  assign idx_nxt   = idx + 6'd1;

  assign busy = (state != IDLE);
  assign done = (state == FINISH);
  assign err  = (state == ERROR);

  // Characters straddle byte boundaries: low nibble of byte n+1, high nibble of byte n+2.
  function automatic logic [7:0] char_at(input logic [351:0] cw, input logic [5:0] n);
    logic [9:0] base;
    base    = {1'b0, n, 3'b000} + 10'd8;
    char_at = {cw[base +: 4], cw[base + 10'd12 +: 4]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_hit) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (start && !abort) state_nxt = HEADER;
        HEADER: begin
          if (mode != 4'b0100)  state_nxt = ERROR;
          else if (len > 8'd42) state_nxt = ERROR;
          else if (len == 8'd0) state_nxt = FINISH;
          else                  state_nxt = STREAM;
        end
        STREAM: if (hs && out_last) state_nxt = FINISH;
        FINISH: state_nxt = IDLE;
        ERROR:  state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      if (state == IDLE && start && !abort) begin
        cw_q     <= codeword;
        err_code <= 2'b00;
      end
      if (abort_hit) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        idx       <= '0;
      end else begin
        case (state)
          HEADER: begin
            if (mode != 4'b0100) begin
              err_code <= 2'b01;
            end else if (len > 8'd42) begin
              err_code <= 2'b10;
            end else if (len != 8'd0) begin
              idx       <= '0;
              out_valid <= 1'b1;
              out_data  <= char_at(cw_q, 6'd0);
              out_last  <= (len == 8'd1);
            end
          end
          STREAM: begin
            if (hs) begin
              if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
              end else begin
                idx      <= idx_nxt;
                out_data <= char_at(cw_q, idx_nxt);
                out_last <= ({2'b00, idx_nxt} == (len - 8'd1));
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qr_text_ctrl.sv
// Directed bench for qr_text_ctrl: header checks, streaming with stalls, abort and mid-stream reset.
module tb_qr_text_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [351:0] codeword;
  logic         abort;
  logic         out_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   err_code;

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  int         last_pos;
  int         hold_bad;
  bit         saw_done;

  qr_text_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .codeword(codeword), .abort(abort),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [351:0] mk5(input logic [7:0] b0, b1, b2, b3, b4);
    logic [351:0] c;
    c = '0;
    c[7:0] = b0; c[15:8] = b1; c[23:16] = b2; c[31:24] = b3; c[39:32] = b4;
    return c;
  endfunction

  task automatic do_start(input logic [351:0] cw);
    codeword = cw;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Drains the stream until done, recording accepted characters and any stall instability.
  task automatic collect(input bit stall, input int maxcyc);
    logic       prev_v, prev_r, prev_l;
    logic [7:0] prev_d;
    logic       r;
    got.delete();
    last_pos = -1; hold_bad = 0; saw_done = 0;
    prev_v = 0; prev_r = 1; prev_l = 0; prev_d = 0;
    for (int n = 0; n < maxcyc; n++) begin
      if (prev_v && !prev_r && (!out_valid || out_data !== prev_d || out_last !== prev_l))
        hold_bad++;
      if (done) begin
        saw_done = 1;
        break;
      end
      r = stall ? ((n % 3) == 0) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        got.push_back(out_data);
        if (out_last) last_pos = got.size() - 1;
      end
      prev_v = out_valid; prev_r = r; prev_d = out_data; prev_l = out_last;
      step();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; out_ready = 1; codeword = '1;
    step(); step();
    total++; if ({out_valid, out_last, busy, done, err} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {out_valid, out_last, busy, done, err}); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_err_code: got %b want 00", err_code); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_start(mk5(8'h40, 8'h34, 8'h14, 8'h24, 8'h30));
    codeword = '1;
    total++; if (busy !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL basic_header: busy=%b valid=%b want 1 0", busy, out_valid); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h41 || out_last !== 1'b0) begin bad++; $display("FAIL basic_c0: v=%b d=%h l=%b want 1 41 0", out_valid, out_data, out_last); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h42 || out_last !== 1'b0) begin bad++; $display("FAIL basic_c1: v=%b d=%h l=%b want 1 42 0", out_valid, out_data, out_last); end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 8'h43 || out_last !== 1'b1) begin bad++; $display("FAIL basic_c2: v=%b d=%h l=%b want 1 43 1", out_valid, out_data, out_last); end
    step();
    total++; if (out_valid !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL basic_done: v=%b done=%b want 0 1", out_valid, done); end
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_idle: done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_stall();
    do_start(mk5(8'h40, 8'h34, 8'h14, 8'h24, 8'h30));
    collect(1'b1, 40);
    total++; if (!saw_done) begin bad++; $display("FAIL stall_timeout: done not seen within 40 cycles"); end
    total++; if (got.size() !== 3) begin bad++; $display("FAIL stall_count: got %0d want 3", got.size()); end
    if (got.size() == 3) begin
      total++; if (got[0] !== 8'h41 || got[1] !== 8'h42 || got[2] !== 8'h43) begin bad++; $display("FAIL stall_chars: got %h %h %h want 41 42 43", got[0], got[1], got[2]); end
    end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", hold_bad); end
    total++; if (last_pos !== 2) begin bad++; $display("FAIL stall_last: got pos %0d want 2", last_pos); end
    step();
  endtask

  task automatic test_error();
    do_start(mk5(8'h20, 8'h34, 8'h14, 8'h24, 8'h30));
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early: got %b want 0", err); end
    step();
    total++; if (err !== 1'b1 || err_code !== 2'b01 || out_valid !== 1'b0) begin bad++; $display("FAIL err_mode: err=%b code=%b v=%b want 1 01 0", err, err_code, out_valid); end
    step();
    total++; if (err !== 1'b0 || busy !== 1'b0 || err_code !== 2'b01) begin bad++; $display("FAIL err_sticky: err=%b busy=%b code=%b want 0 0 01", err, busy, err_code); end
    do_start(mk5(8'h42, 8'hB0, 8'h00, 8'h00, 8'h00));
    step();
    total++; if (err !== 1'b1 || err_code !== 2'b10 || out_valid !== 1'b0) begin bad++; $display("FAIL err_len: err=%b code=%b v=%b want 1 10 0", err, err_code, out_valid); end
    step();
  endtask

  task automatic test_len0();
    do_start(mk5(8'h40, 8'h00, 8'h55, 8'h55, 8'h55));
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL len0_clear: code=%b want 00", err_code); end
    step();
    total++; if (done !== 1'b1 || out_valid !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL len0_done: done=%b v=%b err=%b want 1 0 0", done, out_valid, err); end
    step();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL len0_idle: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_len42();
    logic [7:0]   bq [44];
    logic [351:0] cw;
    int           errs;
    bq[0] = 8'h42; bq[1] = 8'hA0;
    for (int k = 2; k < 44; k++) bq[k] = 8'((k * 37 + 5) & 255);
    for (int k = 0; k < 44; k++) cw[8*k +: 8] = bq[k];
    do_start(cw);
    collect(1'b0, 80);
    total++; if (!saw_done) begin bad++; $display("FAIL len42_timeout: done not seen within 80 cycles"); end
    total++; if (got.size() !== 42) begin bad++; $display("FAIL len42_count: got %0d want 42", got.size()); end
    errs = 0;
    for (int n = 0; n < 42 && n < got.size(); n++)
      if (got[n] !== {bq[n+1][3:0], bq[n+2][7:4]}) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL len42_chars: got %0d wrong want 0", errs); end
    if (got.size() == 42) begin
      total++; if (got[41] !== 8'h73) begin bad++; $display("FAIL len42_final: got %h want 73", got[41]); end
    end
    total++; if (last_pos !== 41) begin bad++; $display("FAIL len42_last: got pos %0d want 41", last_pos); end
    step();
  endtask

  task automatic test_abort();
    logic saw;
    out_ready = 1'b1;
    do_start(mk5(8'h40, 8'h34, 8'h14, 8'h24, 8'h30));
    step(); step(); step();
    total++; if (out_data !== 8'h43 || out_last !== 1'b1) begin bad++; $display("FAIL abort_pre: d=%h l=%b want 43 1", out_data, out_last); end
    abort = 1'b1;
    step();
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL abort_idle: busy=%b v=%b l=%b done=%b want 0 0 0 0", busy, out_valid, out_last, done); end
    codeword = mk5(8'h40, 8'h34, 8'h14, 8'h24, 8'h30);
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_ignored: busy=%b want 0", busy); end
    saw = 0;
    for (int n = 0; n < 3; n++) begin
      if (done || busy) saw = 1;
      step();
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL abort_no_done: activity=%b want 0", saw); end
    do_start(mk5(8'h40, 8'h25, 8'h16, 8'h70, 8'h00));
    collect(1'b0, 20);
    total++; if (got.size() !== 2 || !saw_done) begin bad++; $display("FAIL abort_restart_count: got %0d done=%b want 2 1", got.size(), saw_done); end
    if (got.size() == 2) begin
      total++; if (got[0] !== 8'h51 || got[1] !== 8'h67) begin bad++; $display("FAIL abort_restart_chars: got %h %h want 51 67", got[0], got[1]); end
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    do_start(mk5(8'h40, 8'h34, 8'h14, 8'h24, 8'h30));
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre: v=%b want 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if ({out_valid, out_last, busy, done, err} !== 5'b0 || out_data !== 8'h00) begin bad++; $display("FAIL rstmid_async: flags=%b d=%h want 00000 00", {out_valid, out_last, busy, done, err}, out_data); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    do_start(mk5(8'h40, 8'h15, 8'h9A, 8'h00, 8'h00));
    collect(1'b0, 20);
    total++; if (got.size() !== 1 || !saw_done) begin bad++; $display("FAIL rstmid_count: got %0d done=%b want 1 1", got.size(), saw_done); end
    if (got.size() == 1) begin
      total++; if (got[0] !== 8'h59 || last_pos !== 0) begin bad++; $display("FAIL rstmid_char: got %h pos %0d want 59 0", got[0], last_pos); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_error();
    test_len0();
    test_len42();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
